bsg_dff_chain_valid_tap: RTL and testbench

- Parametrised successor to the plain DFF delay chain.
- Each stage carries a valid bit beside the data word. The chain supports:
  - a global advance enable (stall);
  - a synchronous flush;
  - a runtime-selectable output tap, so the delay can vary from 0 to num_stages_p cycles;
  - a live count of valid entries in flight.
- Used for variable-latency alignment of sideband data against pipelined datapaths, and for retiming across long routes with stall support.

---
 rtl/bsg_dff_chain_valid_tap_pkg.sv | 13 +
 rtl/bsg_dff_chain_valid_stage.sv | 39 +++
 rtl/bsg_dff_chain_valid_tap.sv | 109 ++++++++++
 tb/tb_bsg_dff_chain_valid_tap.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_dff_chain_valid_tap_pkg.sv
// Shared constants and helpers for the valid-tagged DFF delay chain.
// Keeps the tap-select width rule in one place for the chain and its stages.
package bsg_dff_chain_valid_tap_pkg;

  // Marker default for parameters that every instantiation must override.
  localparam int bsg_inv_param_lp = 0;

  // Safe clog2: never returns 0, so a 1-entry select still gets one bit.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_dff_chain_valid_stage.sv
// One stage of the delay chain: a valid flag plus a data word.
// The data register may be gated on the incoming valid to save toggling.
module bsg_dff_chain_valid_stage
  import bsg_dff_chain_valid_tap_pkg::*;
#(
  parameter int width_p     = bsg_inv_param_lp,
  parameter bit gate_data_p = 1'b1
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               flush,
  input  logic               v_in,
  input  logic [width_p-1:0] d_in,
  output logic               v_q,
  output logic [width_p-1:0] d_q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= 1'b0;
    end else if (flush) begin
      v_q <= 1'b0;
    end else if (en) begin
      v_q <= v_in;
    end
  end

  // Flush only kills valids; stale data is harmless because the output is masked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q <= '0;
    end else if (!flush && en && (!gate_data_p || v_in)) begin
      d_q <= d_in;
    end
  end

endmodule

// File: rtl/bsg_dff_chain_valid_tap.sv
// Valid-tagged DFF delay chain with stall, flush, runtime output tap
// and a registered count of valid entries in flight.
module bsg_dff_chain_valid_tap
  import bsg_dff_chain_valid_tap_pkg::*;
#(
  parameter  int width_p      = bsg_inv_param_lp,
  parameter  int num_stages_p = 1,
  parameter  bit gate_data_p  = 1'b1,
  localparam int tap_width_lp = safe_clog2(num_stages_p + 1)
)
(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    flush_i,
  input  logic                    v_i,
  input  logic [width_p-1:0]      data_i,
  input  logic [tap_width_lp-1:0] tap_sel_i,
  output logic                    v_o,
  output logic [width_p-1:0]      data_o,
  output logic [tap_width_lp-1:0] count_o
);

  if (num_stages_p == 0) begin : g_passthru

    wire unused = ^{clk_i, reset_i, en_i, flush_i, tap_sel_i};

    assign v_o     = v_i;
    assign data_o  = v_i ? data_i : '0;
    assign count_o = '0;

  end else begin : g_chain

    logic               v_chain [0:num_stages_p];
    logic [width_p-1:0] d_chain [0:num_stages_p];
    logic [tap_width_lp-1:0] count_r;
    logic               v_sel;
    logic [width_p-1:0] d_sel;

    assign v_chain[0] = v_i;
    assign d_chain[0] = data_i;

    for (genvar k = 1; k <= num_stages_p; k++) begin : g_stage
      bsg_dff_chain_valid_stage #(
        .width_p     (width_p),
        .gate_data_p (gate_data_p)
      ) stage (
        .clk   (clk_i),
        .reset (reset_i),
        .en    (en_i),
        .flush (flush_i),
        .v_in  (v_chain[k-1]),
        .d_in  (d_chain[k-1]),
        .v_q   (v_chain[k]),
        .d_q   (d_chain[k])
      );
    end

    // Incremental count: one entry may enter and one may leave per enabled edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        count_r <= '0;
      end else if (flush_i) begin
        count_r <= '0;
      end else if (en_i) begin
        count_r <= count_r + tap_width_lp'(v_i) - tap_width_lp'(v_chain[num_stages_p]);
      end
    end

    always_comb begin
      v_sel = 1'b0;
      d_sel = '0;
      for (int k = 0; k <= num_stages_p; k++) begin
        if (tap_sel_i == tap_width_lp'(k)) begin
          v_sel = v_chain[k];
          d_sel = d_chain[k];
        end
      end
    end

    assign v_o     = v_sel;
    assign data_o  = v_sel ? d_sel : '0;
    assign count_o = count_r;

`ifndef SYNTHESIS
    logic [tap_width_lp-1:0] pop_valid;

    always_comb begin
      pop_valid = '0;
      for (int k = 1; k <= num_stages_p; k++) begin
        pop_valid = pop_valid + tap_width_lp'(v_chain[k]);
      end
    end

    always @(posedge clk_i) begin
      if (!reset_i) begin
        assert (width_p >= 1)
          else $error("width_p must be at least 1");
        assert (int'(count_r) <= num_stages_p)
          else $error("count out of range: %0d", count_r);
        assert (count_r == pop_valid)
          else $error("count %0d disagrees with valid popcount %0d", count_r, pop_valid);
      end
    end
`endif

  end

endmodule

// File: tb/tb_bsg_dff_chain_valid_tap.sv
// Self-checking bench for the valid-tagged tap chain (N=3 main, plus N=2 and N=0 builds).
// A small reference pipeline plus a tap-3 scoreboard queue supply all expected values.
module tb_bsg_dff_chain_valid_tap;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic       flush;
  logic       v_in;
  logic [7:0] data_in;
  logic [1:0] tap_sel;
  logic [1:0] tap_sel2;
  logic [0:0] tap_sel0;

  logic       v_out,  v_out2,  v_out0;
  logic [7:0] data_out, data_out2, data_out0;
  logic [1:0] count_out, count_out2;
  logic [0:0] count_out0;

  int vector_count = 0;
  int miss_count   = 0;

  logic       mv [1:3];
  logic [7:0] md [1:3];
  logic [7:0] sbq [$];

  always #5 clock = ~clock;

  bsg_dff_chain_valid_tap #(.width_p(8), .num_stages_p(3), .gate_data_p(1'b1)) dut (
    .clk_i(clock), .reset_i(reset), .en_i(en), .flush_i(flush), .v_i(v_in),
    .data_i(data_in), .tap_sel_i(tap_sel), .v_o(v_out), .data_o(data_out), .count_o(count_out)
  );

  bsg_dff_chain_valid_tap #(.width_p(8), .num_stages_p(2), .gate_data_p(1'b1)) dut2 (
    .clk_i(clock), .reset_i(reset), .en_i(en), .flush_i(flush), .v_i(v_in),
    .data_i(data_in), .tap_sel_i(tap_sel2), .v_o(v_out2), .data_o(data_out2), .count_o(count_out2)
  );

  bsg_dff_chain_valid_tap #(.width_p(8), .num_stages_p(0), .gate_data_p(1'b1)) dut0 (
    .clk_i(clock), .reset_i(reset), .en_i(en), .flush_i(flush), .v_i(v_in),
    .data_i(data_in), .tap_sel_i(tap_sel0), .v_o(v_out0), .data_o(data_out0), .count_o(count_out0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic expV(input int tap);
    if (tap == 0) return v_in;
    return mv[tap];
  endfunction

  function automatic logic [7:0] expD(input int tap);
    if (!expV(tap)) return 8'h00;
    return (tap == 0) ? data_in : md[tap];
  endfunction

  function automatic int expCount(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) c += int'(mv[k]);
    return c;
  endfunction

  task automatic modelReset();
    for (int k = 1; k <= 3; k++) begin
      mv[k] = 1'b0;
      md[k] = 8'h00;
    end
    sbq.delete();
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic e, input logic f);
    v_in    = v;
    data_in = d;
    en      = e;
    flush   = f;
    #1;
  endtask

  // Reference update computed from the inputs held across the coming edge.
  task automatic advance();
    logic       nv [1:3];
    logic [7:0] nd [1:3];
    nv = mv;
    nd = md;
    if (flush) begin
      for (int k = 1; k <= 3; k++) nv[k] = 1'b0;
      sbq.delete();
    end else if (en) begin
      for (int k = 3; k >= 2; k--) begin
        nv[k] = mv[k-1];
        if (mv[k-1]) nd[k] = md[k-1];
      end
      nv[1] = v_in;
      if (v_in) begin
        nd[1] = data_in;
        sbq.push_back(data_in);
      end
    end
    @(posedge clock);
    #1;
    mv = nv;
    md = nd;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_v"}, 32'(v_out), 32'(expV(int'(tap_sel))));
    checkOutput({tag, "_d"}, 32'(data_out), 32'(expD(int'(tap_sel))));
    checkOutput({tag, "_cnt"}, 32'(count_out), 32'(expCount(3)));
  endtask

  task automatic checkStream();
    if (tap_sel == 2'd3 && v_out) begin
      if (sbq.size() == 0) checkOutput("sb_underflow", 32'(v_out), 32'd0);
      else checkOutput("sb_data", 32'(data_out), 32'(sbq.pop_front()));
    end
  endtask

  initial begin
    int exp_cnt [6] = '{1, 2, 3, 2, 1, 0};
    logic [7:0] fill [3] = '{8'h11, 8'h22, 8'h33};

    reset = 1'b1; tap_sel = 2'd3; tap_sel2 = 2'd0; tap_sel0 = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    modelReset();
    checkOutput("rst_v", 32'(v_out), 32'd0);
    checkOutput("rst_d", 32'(data_out), 32'd0);
    checkOutput("rst_cnt", 32'(count_out), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkModel("post_rst");

    // Latency: three entries then bubbles, observed at tap 3.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i < 3, (i < 3) ? fill[i] : 8'h00, 1'b1, 1'b0);
      advance();
      checkOutput("lat_cnt", 32'(count_out), 32'(exp_cnt[i]));
      checkModel("lat");
      checkStream();
    end

    // Stall: hold A1,A2 for four cycles.
    applyStimulus(1'b1, 8'hA1, 1'b1, 1'b0); advance();
    applyStimulus(1'b1, 8'hA2, 1'b1, 1'b0); advance();
    tap_sel = 2'd2;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      advance();
      checkOutput("stall_cnt", 32'(count_out), 32'd2);
      checkOutput("stall_d", 32'(data_out), 32'hA1);
      checkModel("stall");
    end
    tap_sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      advance();
      checkModel("resume");
      checkStream();
    end
    checkOutput("resume_drained", 32'(sbq.size()), 32'd0);

    // Flush collides with a new entry.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'hB1 + 8'(i), 1'b1, 1'b0);
      advance();
    end
    checkOutput("full_cnt", 32'(count_out), 32'd3);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b1);
    advance();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("flush_cnt", 32'(count_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      for (int t = 1; t <= 3; t++) begin
        tap_sel = 2'(t);
        #1;
        checkOutput("flush_v", 32'(v_out), 32'd0);
        checkOutput("flush_d", 32'(data_out), 32'd0);
      end
      advance();
    end

    // Tap switch mid-stream.
    tap_sel = 2'd3;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
      advance();
      checkModel("stream");
    end
    checkOutput("pre_switch", 32'(data_out), 32'h03);
    tap_sel = 2'd1;
    #1;
    checkOutput("post_switch", 32'(data_out), 32'h05);
    for (int i = 6; i <= 8; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
      advance();
      checkModel("tap1");
    end
    tap_sel = 2'd0;
    applyStimulus(1'b1, 8'h9A, 1'b1, 1'b0);
    checkOutput("tap0_v", 32'(v_out), 32'd1);
    checkOutput("tap0_d", 32'(data_out), 32'h9A);
    tap_sel2 = 2'd2;
    #1;
    checkOutput("n2_tap2", 32'(data_out2), 32'h07);
    checkOutput("n2_cnt", 32'(count_out2), 32'(expCount(2)));
    tap_sel2 = 2'd3;
    #1;
    checkOutput("n2_oob_v", 32'(v_out2), 32'd0);
    checkOutput("n2_oob_d", 32'(data_out2), 32'd0);

    // Gating plus asynchronous reset between edges.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1); advance();
    applyStimulus(1'b1, 8'hC1, 1'b1, 1'b0); advance();
    applyStimulus(1'b1, 8'hC2, 1'b1, 1'b0); advance();
    applyStimulus(1'b0, 8'hFF, 1'b1, 1'b0); advance();
    tap_sel = 2'd1;
    #1;
    checkOutput("gate_v", 32'(v_out), 32'd0);
    checkOutput("gate_d", 32'(data_out), 32'd0);
    tap_sel = 2'd3;
    #1;
    checkOutput("gate_tap3", 32'(data_out), 32'hC1);
    checkOutput("gate_cnt", 32'(count_out), 32'd2);
    reset = 1'b1;
    #1;
    checkOutput("async_cnt", 32'(count_out), 32'd0);
    checkOutput("async_v", 32'(v_out), 32'd0);
    checkOutput("async_d", 32'(data_out), 32'd0);
    modelReset();
    @(negedge clock);
    reset = 1'b0;

    // Zero-stage build.
    applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0);
    checkOutput("n0_v", 32'(v_out0), 32'd1);
    checkOutput("n0_d", 32'(data_out0), 32'h3C);
    checkOutput("n0_cnt", 32'(count_out0), 32'd0);
    applyStimulus(1'b0, 8'h3C, 1'b1, 1'b0);
    checkOutput("n0_v_off", 32'(v_out0), 32'd0);
    checkOutput("n0_d_off", 32'(data_out0), 32'd0);
    advance();
    checkOutput("n0_cnt_end", 32'(count_out0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
